// File: rtl/profile_buffer.sv
// Ping-pong frame buffer for laser-line midpoints coming from skeletonize.
// One bank captures the current frame while the other is held for the consumer until it is acked.
module profile_buffer #(
   parameter int ROWS  = 480,
   parameter int ROW_W = 9,
   parameter int COL_W = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       fvh_in,
   input  logic [ROW_W-1:0] current_row,
   input  logic [COL_W-1:0] midpoint,
   input  logic             rd_req,
   input  logic [ROW_W-1:0] rd_addr,
   input  logic             frame_ack,
   output logic [COL_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             frame_ready,
   output logic [ROW_W-1:0] valid_rows,
   output logic [7:0]       drop_count
);

   localparam int             AW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ROW_W:0] ROWS_L = (ROW_W+1)'(ROWS);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_CAPT = 2'd1,
      W_SWAP = 2'd2
   } wstate_t;

   wstate_t          state_r;
   wstate_t          state_nxt_s;
   logic [1:0]       fvh_r;
   logic             line_stb_r;
   logic             new_frame_s;
   logic             new_line_s;
   logic             row_ok_s;
   logic             rd_ok_s;
   logic             wr_en_s;
   logic             clr_cnt_s;
   logic             swap_s;
   logic             drop_s;
   logic             wbank_r;
   logic [ROW_W-1:0] rows_seen_r;
   logic [ROW_W-1:0] valid_cnt_r;
   logic [COL_W-1:0] rd_data_r;
   logic             rd_valid_r;
   logic             frame_ready_r;
   logic [ROW_W-1:0] valid_rows_r;
   logic [7:0]       drop_count_r;
   logic [COL_W-1:0] mem0_r [ROWS];
   logic [COL_W-1:0] mem1_r [ROWS];
   logic             unused_fvh_s;

   // The F flag is carried alongside V/H but plays no part in capture.
   assign unused_fvh_s = fvh_in[2];

   assign new_frame_s = fvh_in[1] & ~fvh_r[1];
   assign new_line_s  = fvh_in[0] & ~fvh_r[0];
   assign row_ok_s    = ({1'b0, current_row} < ROWS_L);
   assign rd_ok_s     = ({1'b0, rd_addr} < ROWS_L);

   // Edge detection history and the one-cycle delayed line strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fvh_r      <= 2'b00;
         line_stb_r <= 1'b0;
      end else begin
         fvh_r      <= fvh_in[1:0];
         line_stb_r <= new_line_s;
      end
   end

   // Write FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= W_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write FSM next state and control strobes; a line coinciding with new_frame counts toward the frame.
   always_comb begin
      state_nxt_s = state_r;
      wr_en_s     = 1'b0;
      clr_cnt_s   = 1'b0;
      swap_s      = 1'b0;
      drop_s      = 1'b0;
      case (state_r)
         W_IDLE: begin
            if (new_frame_s) begin
               state_nxt_s = W_CAPT;
               clr_cnt_s   = 1'b1;
            end else begin
               state_nxt_s = W_IDLE;
            end
         end
         W_CAPT: begin
            wr_en_s = line_stb_r & row_ok_s;
            if (new_frame_s) begin
               if ((rows_seen_r == {ROW_W{1'b0}}) && !wr_en_s) begin
                  state_nxt_s = W_CAPT;
                  clr_cnt_s   = 1'b1;
               end else begin
                  state_nxt_s = W_SWAP;
               end
            end else begin
               state_nxt_s = W_CAPT;
            end
         end
         W_SWAP: begin
            state_nxt_s = W_CAPT;
            clr_cnt_s   = 1'b1;
            if (!frame_ready_r || frame_ack) begin
               swap_s = 1'b1;
            end else begin
               drop_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = W_IDLE;
         end
      endcase
   end

   // Per-frame row and non-zero midpoint counters (saturating).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rows_seen_r <= {ROW_W{1'b0}};
         valid_cnt_r <= {ROW_W{1'b0}};
      end else if (clr_cnt_s) begin
         rows_seen_r <= {ROW_W{1'b0}};
         valid_cnt_r <= {ROW_W{1'b0}};
      end else if (wr_en_s) begin
         if (rows_seen_r != {ROW_W{1'b1}}) begin
            rows_seen_r <= rows_seen_r + ROW_W'(1);
         end
         if ((midpoint != {COL_W{1'b0}}) && (valid_cnt_r != {ROW_W{1'b1}})) begin
            valid_cnt_r <= valid_cnt_r + ROW_W'(1);
         end
      end
   end

   // Bank ownership, hand-off flag and drop accounting; a swap overrides a coincident ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wbank_r       <= 1'b0;
         frame_ready_r <= 1'b0;
         valid_rows_r  <= {ROW_W{1'b0}};
         drop_count_r  <= 8'd0;
      end else begin
         if (swap_s) begin
            wbank_r       <= ~wbank_r;
            frame_ready_r <= 1'b1;
            valid_rows_r  <= valid_cnt_r;
         end else if (frame_ack && frame_ready_r) begin
            frame_ready_r <= 1'b0;
         end
         if (drop_s && (drop_count_r != 8'hFF)) begin
            drop_count_r <= drop_count_r + 8'd1;
         end
      end
   end

   // Midpoint storage; only the write bank is ever written.
   always_ff @(posedge clk) begin
      if (wr_en_s && !wbank_r) begin
         mem0_r[current_row[AW-1:0]] <= midpoint;
      end
      if (wr_en_s && wbank_r) begin
         mem1_r[current_row[AW-1:0]] <= midpoint;
      end
   end

   // Synchronous read port on the bank not being written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_r  <= {COL_W{1'b0}};
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_req;
         if (rd_req) begin
            if (!rd_ok_s) begin
               rd_data_r <= {COL_W{1'b0}};
            end else if (wbank_r) begin
               rd_data_r <= mem0_r[rd_addr[AW-1:0]];
            end else begin
               rd_data_r <= mem1_r[rd_addr[AW-1:0]];
            end
         end
      end
   end

   assign rd_data     = rd_data_r;
   assign rd_valid    = rd_valid_r;
   assign frame_ready = frame_ready_r;
   assign valid_rows  = valid_rows_r;
   assign drop_count  = drop_count_r;

endmodule
